regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file with a built-in scoreboard and write-to-read bypass. It serves the decode/issue stage: NRD combinational read ports, one write-back port, and per-register busy bits so issue logic can stall on RAW hazards. The storage array has no reset. After reset, or on request, a sweep state machine clears it one entry per cycle, so the array can map onto RAM-style macros.

Parameters:
XLEN, 64, data width of each register
NREG, 32, number of registers (power of two, >=2)
AW, $clog2(NREG), register address width
NRD, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
ZERO_REG, 1, 1 = register 0 is hardwired to zero, never busy, and ignores writes

Ports:
core_clk  input  1  clock
core_rst_n  input  1  asynchronous active-low reset
core_clk_en  input  1  global enable; when 0, no state changes
wr_en  input  1  write-back valid
wr_addr  input  AW  write-back destination
wr_data  input  XLEN  write-back data
rd_addr  input  NRD*AW  read addresses; port k is bits [k*AW +: AW]
rd_data  output  NRD*XLEN  read data; port k is bits [k*XLEN +: XLEN]
rd_ready  output  NRD  port k operand valid (not busy, or bypassed)
iss_en  input  1  instruction issued; marks destination busy
iss_rd  input  AW  issued destination register
flush  input  1  clear all busy bits (pipeline flush)
clr_req  input  1  request a full register clear (re-enter sweep)
init_busy  output  1  sweep in progress; the block is unusable

Behaviour:
- Clock and reset: one clock, core_clk. Reset core_rst_n is asynchronous and active-low.
- Reset values:
  - state = INIT; sweep index idx = 0; busy[] = all 0.
  - Storage array is not reset.
  - init_busy = 1; rd_data = 0; rd_ready = 0.
- State machine (2 states):
  - INIT: each core_clk_en cycle writes 0 to entry idx, then idx++. The cycle writing entry NREG-1 moves to RUN; idx returns to 0.
  - The sweep takes exactly NREG enabled cycles. If core_clk_en = 0, the sweep pauses.
  - In INIT: wr_en, iss_en, flush and clr_req are ignored; rd_data = 0; rd_ready = 0; init_busy = 1.
  - RUN: init_busy = 0. clr_req (with core_clk_en) moves to INIT next cycle with idx = 0 and clears all busy bits. The same-cycle write and issue in that cycle are discarded.
- Write (RUN, core_clk_en): wr_en writes wr_data to array[wr_addr] at the posedge. With ZERO_REG = 1, a write to address 0 is dropped.
- Read: combinational from rd_addr.
  - With ZERO_REG = 1, address 0 returns 0 and ready = 1.
  - Bypass hit: BYPASS = 1 and wr_en & core_clk_en & state = RUN & wr_addr == rd_addr[k] & (addr != 0 or ZERO_REG = 0). On a hit, rd_data[k] = wr_data and rd_ready[k] = 1.
  - Otherwise rd_data[k] = array[addr] and rd_ready[k] = !busy[addr].
  - BYPASS = 0 gives write-then-read: new data is visible the cycle after the write.
- Scoreboard (RUN, core_clk_en), per entry, in priority order:
  - flush: busy <= 0 for every entry. flush beats a same-cycle issue.
  - iss_en & iss_rd == i (i != 0 when ZERO_REG = 1): busy[i] <= 1. A same-cycle write-back to i does not clear it; the new producer wins.
  - wr_en & wr_addr == i: busy[i] <= 0.
  - One outstanding producer per register; issue logic guarantees this.
- Reset mid-sweep or mid-operation: returns to INIT with idx = 0 immediately (asynchronous), and the sweep restarts.
- rd_ready is purely combinational from busy, the bypass terms and state; there are no extra pipeline registers, so read latency is 0 cycles.

Decomposition:
- Shared package/include: the state encodings RF_INIT and RF_RUN, and default XLEN/NREG macros alongside the existing core defines.
- One natural sub-module: regfile_sb_scoreboard. It holds the NREG busy bits with set/clear/flush priority and takes the address-decode inputs.
- Array, sweep FSM and bypass muxing stay in the top.

Test Plan:
1. Release reset with core_clk_en = 1 and NREG = 32 -> init_busy = 1 for exactly 32 cycles, then 0; every register reads 0; rd_ready = all 1.
2. RUN: wr_en, wr_addr = 5, wr_data = 0xDEAD_BEEF, with rd_addr port0 = 5 in the same cycle -> BYPASS = 1: same-cycle rd_data = 0xDEAD_BEEF. BYPASS = 0: old value (0) that cycle, new value next cycle.
3. Write to x0 with 0x1234, then read x0 -> rd_data = 0 and rd_ready = 1. Issue iss_rd = 0 -> no busy bit set.
4. Issue iss_rd = 7 -> rd_ready for x7 = 0 on following cycles. Write-back wr_addr = 7 -> ready in the same cycle via bypass, and stays 1 afterward. Issue to 7 plus write-back to 7 in the same cycle -> x7 stays busy.
5. Set busy on x3, x9 and x12, then assert flush together with iss_rd = 4 -> all busy bits 0, including x4.
6. Write x10 = 0x55, assert clr_req -> 32-cycle sweep, with wr_en ignored during it, then x10 reads 0. Pulse core_rst_n low at sweep index 10 -> sweep restarts from 0 and completes in 32 cycles.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_pkg
//  Description : Shared definitions for the regfile_sb register file:
//                sweep/run state encodings and default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_sb_pkg;

    // Default register-file geometry
    localparam int RF_DEF_XLEN = 64;
    localparam int RF_DEF_NREG = 32;

    // INIT: clearing sweep in progress, block unusable
    // RUN : normal operation
    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

endpackage : regfile_sb_pkg
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_scoreboard
//  Description : NREG busy bits for RAW-hazard tracking.
//                Per-entry priority: flush_all > set (issue) > clear (write-back).
//  Ports       : core_clk, core_rst_n (async, active-low)
//                en        - qualifies every update (clock enable & RUN)
//                flush_all - clear every busy bit
//                set_en/set_addr - mark a destination busy
//                clr_en/clr_addr - write-back releases a register
//                busy      - current busy vector
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            core_clk,
    input  logic            core_rst_n,
    input  logic            en,
    input  logic            flush_all,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (en) begin
            for (int i = 0; i < NREG; i++) begin
                if (flush_all) begin
                    busy_d[i] = 1'b0;
                end else if (set_en && (set_addr == AW'(i)) && !(ZERO_REG && (i == 0))) begin
                    // A new producer wins over a same-cycle write-back of the old one
                    busy_d[i] = 1'b1;
                end else if (clr_en && (clr_addr == AW'(i))) begin
                    busy_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule : regfile_sb_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Integer register file with scoreboard and write-to-read
//                bypass. Storage has no reset; a sweep FSM zeroes one entry
//                per enabled cycle after reset or on clr_req.
//  Ports       : core_clk, core_rst_n (async, active-low), core_clk_en
//                wr_en/wr_addr/wr_data   - write-back port
//                rd_addr/rd_data/rd_ready - NRD combinational read ports
//                iss_en/iss_rd            - issue marks destination busy
//                flush                    - clear all busy bits
//                clr_req                  - restart the clearing sweep
//                init_busy                - sweep in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN     = RF_DEF_XLEN,
    parameter int NREG     = RF_DEF_NREG,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                core_clk,
    input  logic                core_rst_n,
    input  logic                core_clk_en,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    input  logic                clr_req,
    output logic                init_busy
);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] w_busy;

    logic            w_run_en;
    logic            w_wb_fwd;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [XLEN-1:0] w_mem_data;

    assign w_run_en  = core_clk_en && (state_q == RF_RUN);
    // Forwarding condition does not look at clr_req; the array write does
    assign w_wb_fwd  = w_run_en && wr_en;
    assign init_busy = (state_q == RF_INIT);

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (core_clk_en) begin
            case (state_q)
                RF_INIT: begin
                    idx_d = idx_q + AW'(1);
                    if (idx_q == AW'(NREG - 1)) begin
                        state_d = RF_RUN;
                        idx_d   = '0;
                    end
                end
                RF_RUN: begin
                    if (clr_req) begin
                        state_d = RF_INIT;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = RF_INIT;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q <= RF_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage: single write port shared by the sweep and write-back
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = wr_addr;
        w_mem_data = wr_data;
        if (core_clk_en && (state_q == RF_INIT)) begin
            w_mem_we   = 1'b1;
            w_mem_addr = idx_q;
            w_mem_data = '0;
        end else if (w_wb_fwd && !clr_req && !(ZERO_REG && (wr_addr == '0))) begin
            w_mem_we   = 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (w_mem_we) begin
            mem[w_mem_addr] <= w_mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard; clr_req clears busy and discards the same-cycle issue
    // ------------------------------------------------------------------
    regfile_sb_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .en         (w_run_en),
        .flush_all  (flush || clr_req),
        .set_en     (iss_en && !clr_req),
        .set_addr   (iss_rd),
        .clr_en     (wr_en),
        .clr_addr   (wr_addr),
        .busy       (w_busy)
    );

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_rdy;

        assign w_addr = rd_addr[k*AW +: AW];

        always_comb begin
            w_data = '0;
            w_rdy  = 1'b0;
            if (state_q == RF_RUN) begin
                if (ZERO_REG && (w_addr == '0)) begin
                    w_rdy = 1'b1;
                end else if (BYPASS && w_wb_fwd && (wr_addr == w_addr)) begin
                    w_data = wr_data;
                    w_rdy  = 1'b1;
                end else begin
                    w_data = mem[w_addr];
                    w_rdy  = !w_busy[w_addr];
                end
            end
        end

        assign rd_data[k*XLEN +: XLEN] = w_data;
        assign rd_ready[k]             = w_rdy;
    end

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Self-checking bench for regfile_sb. One bypassing instance
//                and one non-bypassing instance share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic                core_clk;
    logic                core_rst_n;
    logic                core_clk_en;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data, nb_rd_data;
    logic [NRD-1:0]      rd_ready, nb_rd_ready;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic                clr_req;
    logic                init_busy, nb_init_busy;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n), .core_clk_en(core_clk_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .clr_req(clr_req),
        .init_busy(init_busy)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_nb (
        .core_clk(core_clk), .core_rst_n(core_rst_n), .core_clk_en(core_clk_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_ready(nb_rd_ready),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .clr_req(clr_req),
        .init_busy(nb_init_busy)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [63:0]   wd;
        logic          ie;
        logic [AW-1:0] ir;
        logic          fl;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [63:0]   d0;
        logic          r0;
        logic [63:0]   d1;
        logic          r1;
        logic [63:0]   n0;   // port-0 data of the non-bypassing instance
        logic          nr0;  // port-0 ready of the non-bypassing instance
    } vec_t;

    function automatic vec_t mk(int we, int wa, logic [63:0] wd, int ie, int ir, int fl,
                                int a0, int a1, logic [63:0] d0, int r0,
                                logic [63:0] d1, int r1, logic [63:0] n0, int nr0);
        vec_t v;
        v.we = we[0]; v.wa = wa[AW-1:0]; v.wd = wd;
        v.ie = ie[0]; v.ir = ir[AW-1:0]; v.fl = fl[0];
        v.a0 = a0[AW-1:0]; v.a1 = a1[AW-1:0];
        v.d0 = d0; v.r0 = r0[0]; v.d1 = d1; v.r1 = r1[0];
        v.n0 = n0; v.nr0 = nr0[0];
        return v;
    endfunction

    task automatic chk64(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_rd = '0; flush = 1'b0; clr_req = 1'b0;
    endtask

    // Counts enabled edges until init_busy drops; bounded
    task automatic count_sweep(output int n);
        n = 0;
        while (init_busy && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL sweep_timeout: init_busy still 1 after %0d cycles", n);
        end
    endtask

    vec_t vt[18];
    int   n;

    initial begin
        core_rst_n = 1'b0; core_clk_en = 1'b1; rd_addr = '0;
        idle_inputs();

        vt[0]  = mk(1, 5, 64'hDEADBEEF, 0, 0, 0,  5,  6, 64'hDEADBEEF, 1, 64'h0, 1, 64'h0, 1);
        vt[1]  = mk(0, 0, 64'h0,        0, 0, 0,  5,  0, 64'hDEADBEEF, 1, 64'h0, 1, 64'hDEADBEEF, 1);
        vt[2]  = mk(1, 0, 64'h1234,     0, 0, 0,  0,  5, 64'h0, 1, 64'hDEADBEEF, 1, 64'h0, 1);
        vt[3]  = mk(0, 0, 64'h0,        1, 0, 0,  0,  5, 64'h0, 1, 64'hDEADBEEF, 1, 64'h0, 1);
        vt[4]  = mk(0, 0, 64'h0,        1, 7, 0,  0,  7, 64'h0, 1, 64'h0, 1, 64'h0, 1);
        vt[5]  = mk(0, 0, 64'h0,        0, 0, 0,  7,  5, 64'h0, 0, 64'hDEADBEEF, 1, 64'h0, 0);
        vt[6]  = mk(1, 7, 64'hABC,      0, 0, 0,  7,  7, 64'hABC, 1, 64'hABC, 1, 64'h0, 0);
        vt[7]  = mk(0, 0, 64'h0,        0, 0, 0,  7,  0, 64'hABC, 1, 64'h0, 1, 64'hABC, 1);
        vt[8]  = mk(1, 7, 64'h777,      1, 7, 0,  7,  0, 64'h777, 1, 64'h0, 1, 64'hABC, 1);
        vt[9]  = mk(0, 0, 64'h0,        0, 0, 0,  7,  3, 64'h777, 0, 64'h0, 1, 64'h777, 0);
        vt[10] = mk(0, 0, 64'h0,        1, 3, 0,  7,  3, 64'h777, 0, 64'h0, 1, 64'h777, 0);
        vt[11] = mk(0, 0, 64'h0,        1, 9, 0,  3,  9, 64'h0, 0, 64'h0, 1, 64'h0, 0);
        vt[12] = mk(0, 0, 64'h0,        1, 12, 0, 9,  3, 64'h0, 0, 64'h0, 0, 64'h0, 0);
        vt[13] = mk(0, 0, 64'h0,        1, 4, 1,  12, 4, 64'h0, 0, 64'h0, 1, 64'h0, 0);
        vt[14] = mk(0, 0, 64'h0,        0, 0, 0,  4,  12, 64'h0, 1, 64'h0, 1, 64'h0, 1);
        vt[15] = mk(0, 0, 64'h0,        0, 0, 0,  7,  9, 64'h777, 1, 64'h0, 1, 64'h777, 1);
        vt[16] = mk(1, 10, 64'h55,      0, 0, 0,  10, 3, 64'h55, 1, 64'h0, 1, 64'h0, 1);
        vt[17] = mk(0, 0, 64'h0,        0, 0, 0,  10, 3, 64'h55, 1, 64'h0, 1, 64'h55, 1);

        // ---------------- Reset and initial sweep ----------------
        rd_addr = {5'd0, 5'd5};
        step(); step();
        chk1("rst_init_busy", init_busy, 1'b1);
        chk1("rst_rd_ready0", rd_ready[0], 1'b0);
        chk1("rst_rd_ready_x0", rd_ready[1], 1'b0);
        chk64("rst_rd_data0", rd_data[63:0], 64'h0);
        core_rst_n = 1'b1;
        count_sweep(n);
        chk64("init_sweep_len", 64'(n), 64'd32);
        chk1("init_nb_done", nb_init_busy, 1'b0);
        for (int r = 0; r < 16; r++) begin
            rd_addr = {5'(r + 16), 5'(r)};
            #1;
            chk64($sformatf("init_x%0d", r), rd_data[63:0], 64'h0);
            chk64($sformatf("init_x%0d", r + 16), rd_data[127:64], 64'h0);
            chk64($sformatf("init_rdy_%0d", r), 64'(rd_ready), 64'h3);
        end
        step();

        // ---------------- Directed vector table ----------------
        for (int i = 0; i < 18; i++) begin
            wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            iss_en = vt[i].ie; iss_rd = vt[i].ir; flush = vt[i].fl;
            rd_addr = {vt[i].a1, vt[i].a0};
            #3;
            chk64($sformatf("v%0d_d0", i), rd_data[63:0], vt[i].d0);
            chk1($sformatf("v%0d_r0", i), rd_ready[0], vt[i].r0);
            chk64($sformatf("v%0d_d1", i), rd_data[127:64], vt[i].d1);
            chk1($sformatf("v%0d_r1", i), rd_ready[1], vt[i].r1);
            chk64($sformatf("v%0d_nb_d0", i), nb_rd_data[63:0], vt[i].n0);
            chk1($sformatf("v%0d_nb_r0", i), nb_rd_ready[0], vt[i].nr0);
            step();
        end
        idle_inputs();

        // ---------------- Clock enable low in RUN ----------------
        core_clk_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h42;
        iss_en = 1'b1; iss_rd = 5'd21;
        rd_addr = {5'd21, 5'd20};
        #3;
        chk64("cen0_nobypass", rd_data[63:0], 64'h0);
        step();
        core_clk_en = 1'b1;
        idle_inputs();
        #3;
        chk64("cen0_nowrite", rd_data[63:0], 64'h0);
        chk1("cen0_noissue", rd_ready[1], 1'b1);
        step();

        // ---------------- clr_req sweep with a pause ----------------
        clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'h99;
        iss_en = 1'b1; iss_rd = 5'd11;
        rd_addr = {5'd11, 5'd10};
        #3;
        chk1("clr_pre_run", init_busy, 1'b0);
        step();
        clr_req = 1'b0; wr_data = 64'hFFFF;
        #1;
        chk1("clr_init_busy", init_busy, 1'b1);
        chk64("clr_rd_zero", rd_data[63:0], 64'h0);
        chk1("clr_rd_notready", rd_ready[0], 1'b0);
        for (int c = 0; c < 5; c++) step();
        core_clk_en = 1'b0;
        for (int c = 0; c < 3; c++) step();
        chk1("clr_paused", init_busy, 1'b1);
        core_clk_en = 1'b1;
        count_sweep(n);
        chk64("clr_remaining_len", 64'(n), 64'd27);
        idle_inputs();
        #1;
        chk64("clr_x10_zero", rd_data[63:0], 64'h0);
        chk1("clr_x10_ready", rd_ready[0], 1'b1);
        chk1("clr_x11_not_busy", rd_ready[1], 1'b1);
        step();

        // ---------------- Reset in the middle of a sweep ----------------
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h5A5A;
        step();
        wr_en = 1'b0;
        rd_addr = {5'd0, 5'd5};
        #1;
        chk64("pre_rst_x5", rd_data[63:0], 64'h5A5A);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 0; c < 10; c++) step();
        core_rst_n = 1'b0;
        #2;
        chk1("midrst_ready", rd_ready[1], 1'b0);
        core_rst_n = 1'b1;
        #1;
        count_sweep(n);
        chk64("midrst_sweep_len", 64'(n), 64'd32);
        #1;
        chk64("midrst_x5_zero", rd_data[63:0], 64'h0);
        chk1("midrst_x5_ready", rd_ready[0], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
